// File: rtl/ports_write_arbiter_pkg.sv
// ports_write_arbiter_pkg
//   Shared constants for the two-requester write arbiter that drives the
//   single-bit-write `ports` bank: port geometry, FSM state encoding and
//   owner identifiers.
package ports_write_arbiter_pkg;

    localparam int PORT_COUNT = 8;
    localparam int IDX_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/ports_write_arbiter_lsb_encoder8.sv
// lsb_encoder8
//   Combinational lowest-set-bit encoder.
//   vec_i  : PORT_COUNT-bit input vector
//   idx_o  : index of the lowest set bit (0 when vec_i is zero)
//   none_o : 1 when vec_i has no bit set
module lsb_encoder8
    import ports_write_arbiter_pkg::*;
(
    input  logic [PORT_COUNT-1:0] vec_i,
    output logic [IDX_W-1:0]      idx_o,
    output logic                  none_o
);

    always_comb begin
        idx_o  = '0;
        none_o = ~|vec_i;
        // Scan downward so the last hit, the lowest index, wins.
        for (int i = PORT_COUNT - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = IDX_W'(i);
        end
    end

endmodule

// File: rtl/ports_write_arbiter.sv
// ports_write_arbiter
//   Shares the single-bit-write `ports` bank between requester A (CPU store
//   path) and requester B (auxiliary master). A request is a data byte and
//   a mask byte; the granted request is serialised into one port-bit write
//   per cycle, lowest masked index first, followed by a one-cycle done pulse.
//   Ports:
//     clk, rst               : clock, synchronous active-high reset
//     a_valid/a_data/a_mask  : requester A request; a_ready = accepted
//     b_valid/b_data/b_mask  : requester B request; b_ready = accepted
//     portWrite/valueWrite/enWrite : write interface into `ports`
//     busy                   : FSM not idle
//     done/done_id           : completion pulse and owner (0 = A, 1 = B)
module ports_write_arbiter
    import ports_write_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    input  logic [PORT_COUNT-1:0] a_data,
    input  logic [PORT_COUNT-1:0] a_mask,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [PORT_COUNT-1:0] b_data,
    input  logic [PORT_COUNT-1:0] b_mask,
    output logic                  b_ready,
    output logic [IDX_W-1:0]      portWrite,
    output logic                  valueWrite,
    output logic                  enWrite,
    output logic                  busy,
    output logic                  done,
    output logic                  done_id
);

    state_e                  state_q, state_d;
    logic [PORT_COUNT-1:0]   data_q;
    logic [PORT_COUNT-1:0]   mask_q;    // working mask, bits cleared as written
    logic                    owner_q;
    logic                    prio_q;    // requester favoured on a tie

    logic                    accept;
    logic [PORT_COUNT-1:0]   mask_in;
    logic [PORT_COUNT-1:0]   data_in;
    logic [IDX_W-1:0]        cur_idx;
    logic                    cur_none;
    logic [PORT_COUNT-1:0]   mask_clr;
    logic [IDX_W-1:0]        rest_idx;
    logic                    rest_none;

    // Bit written this cycle.
    lsb_encoder8 u_cur (
        .vec_i  (mask_q),
        .idx_o  (cur_idx),
        .none_o (cur_none)
    );

    assign mask_clr = mask_q & ~(PORT_COUNT'(1) << cur_idx);

    // Looking at the mask after this write tells us whether it is the last.
    lsb_encoder8 u_rest (
        .vec_i  (mask_clr),
        .idx_o  (rest_idx),
        .none_o (rest_none)
    );

    assign accept  = a_ready | b_ready;
    assign mask_in = b_ready ? b_mask : a_mask;
    assign data_in = b_ready ? b_data : a_data;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = (|mask_in) ? ST_WRITE : ST_DONE;
            ST_WRITE: if (rest_none) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs: writes and status come from registered state only; the
    // ready handshake is combinational on the request inputs.
    always_comb begin
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        enWrite    = 1'b0;
        portWrite  = '0;
        valueWrite = 1'b0;
        done       = 1'b0;
        done_id    = 1'b0;
        busy       = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                a_ready = a_valid & (~b_valid | (prio_q == OWN_A));
                b_ready = b_valid & (~a_valid | (prio_q == OWN_B));
            end
            ST_WRITE: begin
                enWrite    = ~cur_none;
                portWrite  = cur_idx;
                valueWrite = data_q[cur_idx];
            end
            ST_DONE: begin
                done    = 1'b1;
                done_id = owner_q;
            end
            default: ;
        endcase
    end

    // Request datapath: latch on accept, retire one mask bit per write.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            mask_q  <= '0;
            owner_q <= OWN_A;
            prio_q  <= OWN_A;
        end else if (accept) begin
            data_q  <= data_in;
            mask_q  <= mask_in;
            owner_q <= b_ready ? OWN_B : OWN_A;
            prio_q  <= b_ready ? OWN_A : OWN_B;
        end else if (state_q == ST_WRITE) begin
            mask_q  <= mask_clr;
        end
    end

    logic unused_ok;
    assign unused_ok = ^rest_idx;

endmodule

// File: tb/tb_ports_write_arbiter.sv
// tb_ports_write_arbiter
//   Directed bench: a table of single requests with hand-computed port
//   contents, plus sequences for arbitration, mid-write reset and a
//   requester waiting while the other is being serviced.
module tb_ports_write_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic [7:0] a_data = '0, a_mask = '0, b_data = '0, b_mask = '0;
    logic       a_ready, b_ready;
    logic [2:0] portWrite;
    logic       valueWrite, enWrite, busy, done, done_id;

    int tests = 0;
    int fails = 0;

    ports_write_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_mask(a_mask), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_mask(b_mask), .b_ready(b_ready),
        .portWrite(portWrite), .valueWrite(valueWrite), .enWrite(enWrite),
        .busy(busy), .done(done), .done_id(done_id)
    );

    always #5 clk = ~clk;

    // Model of the `ports` bank sharing clk/rst.
    logic [7:0] ports_m;
    always_ff @(posedge clk) begin
        if (rst)          ports_m <= '0;
        else if (enWrite) ports_m[portWrite] <= valueWrite;
    end

    typedef struct {
        logic       who;
        logic [7:0] data;
        logic [7:0] mask;
        int         nwr;
        logic [7:0] exp_ports;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One request from an idle block, checked cycle by cycle.
    task automatic run_vec(input logic who, input logic [7:0] data, input logic [7:0] mask,
                           input int nwr, input logic [7:0] exp_ports);
        int pos;
        @(negedge clk);
        if (who) begin b_valid = 1; b_data = data; b_mask = mask; end
        else     begin a_valid = 1; a_data = data; a_mask = mask; end
        #1;
        chk("ready_sel", {a_ready, b_ready}, who ? 2'b01 : 2'b10);
        @(negedge clk);
        // Inputs after accept must be ignored.
        a_valid = 0; b_valid = 0;
        a_data = ~data; b_data = ~data; a_mask = 8'hFF; b_mask = 8'hFF;
        chk("busy_t1", busy, 1);
        pos = 0;
        for (int k = 0; k < nwr; k++) begin
            while (pos < 8 && !mask[pos]) pos++;
            chk("wr_en", enWrite, 1);
            chk("wr_idx", portWrite, pos);
            chk("wr_val", valueWrite, data[pos]);
            pos++;
            @(negedge clk);
        end
        chk("done_en", enWrite, 0);
        chk("done", done, 1);
        chk("done_id", done_id, who);
        @(negedge clk);
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("ports", ports_m, exp_ports);
    endtask

    initial begin : main
        int   g[8];
        int   ng;
        logic prev_rdy;

        vecs[0] = '{1'b0, 8'hA5, 8'hFF, 8, 8'hA5};
        vecs[1] = '{1'b0, 8'h00, 8'hFF, 8, 8'h00};
        vecs[2] = '{1'b1, 8'hFF, 8'h24, 2, 8'h24};
        vecs[3] = '{1'b0, 8'h00, 8'h00, 0, 8'h24};
        vecs[4] = '{1'b1, 8'h0F, 8'h81, 2, 8'h25};
        vecs[5] = '{1'b0, 8'hC3, 8'h3C, 4, 8'h01};
        vecs[6] = '{1'b1, 8'hFF, 8'h80, 1, 8'h81};

        // Reset state
        repeat (2) @(negedge clk);
        rst = 0;
        chk("rst_en", enWrite, 0);
        chk("rst_pw", portWrite, 0);
        chk("rst_vw", valueWrite, 0);
        chk("rst_done", done, 0);
        chk("rst_id", done_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdy", {a_ready, b_ready}, 0);

        foreach (vecs[i])
            run_vec(vecs[i].who, vecs[i].data, vecs[i].mask, vecs[i].nwr, vecs[i].exp_ports);

        // Round-robin with both requesters always valid.
        @(negedge clk); rst = 1; @(negedge clk); rst = 0;
        a_valid = 1; b_valid = 1; a_mask = 8'h01; b_mask = 8'h01; a_data = 8'h01; b_data = 8'h00;
        ng = 0; prev_rdy = 0;
        for (int c = 0; c < 14; c++) begin
            #1;
            chk("arb_onehot", a_ready & b_ready, 0);
            if (prev_rdy) chk("arb_pulse", a_ready | b_ready, 0);
            if ((a_ready | b_ready) && ng < 8) begin g[ng] = b_ready; ng++; end
            prev_rdy = a_ready | b_ready;
            @(negedge clk);
        end
        a_valid = 0; b_valid = 0;
        chk("arb_count", (ng >= 4), 1);
        chk("arb_order", {g[0][0], g[1][0], g[2][0], g[3][0]}, 4'b0101);

        // Reset after the third write of a full-mask request.
        @(negedge clk); rst = 1; @(negedge clk); rst = 0;
        a_valid = 1; a_data = 8'hFF; a_mask = 8'hFF;
        #1 chk("mr_rdy", a_ready, 1);
        @(negedge clk); a_valid = 0;
        @(negedge clk);
        @(negedge clk);
        chk("mr_wr3", portWrite, 2);
        rst = 1;
        @(negedge clk); rst = 0;
        chk("mr_en", enWrite, 0);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        chk("mr_ports", ports_m, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mr_nodone", done, 0);
        end
        run_vec(1'b0, 8'h3C, 8'h0F, 4, 8'h0C);

        // B held valid while A writes; A data changes mid-write.
        @(negedge clk); rst = 1; @(negedge clk); rst = 0;
        a_valid = 1; a_data = 8'h5A; a_mask = 8'hFF;
        #1 chk("w_ardy", a_ready, 1);
        @(negedge clk);
        a_valid = 0; a_data = 8'h00;
        b_valid = 1; b_data = 8'hFF; b_mask = 8'h01;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) a_data = 8'hFF;
            #1;
            chk("w_brdy", b_ready, 0);
            chk("w_idx", portWrite, k);
            chk("w_val", valueWrite, (8'h5A >> k) & 1);
            @(negedge clk);
        end
        #1;
        chk("w_done", done, 1);
        chk("w_done_brdy", b_ready, 0);
        @(negedge clk);
        #1 chk("w_b_acc", b_ready, 1);
        @(negedge clk);
        b_valid = 0;
        chk("w_b_idx", portWrite, 0);
        chk("w_b_val", valueWrite, 1);
        @(negedge clk);
        chk("w_b_done", done, 1);
        chk("w_b_id", done_id, 1);
        @(negedge clk);
        chk("w_ports", ports_m, 8'h5B);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
